sync_fifo: RTL and testbench

//  Single-clock, parametrised FIFO; successor to the dual-clock generator-core FIFO wrapper used after uart_rx.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/sync_fifo_if.sv | 40 ++++
 rtl/fifo_ram.sv | 25 ++
 rtl/sync_fifo.sv | 126 ++++++++++++
 tb/tb_sync_fifo.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions.
// Count-width helper and default geometry.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  function automatic int fifo_count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// FIFO write/read/status bundle.
// master drives requests, slave is the FIFO.
interface sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);

  localparam int CW = fifo_count_w(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, din, rd_en, clr_err,
    input  dout, dout_valid, full, empty,
    input  almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, clr_err,
    output dout, dout_valid, full, empty,
    output almost_full, almost_empty,
    output count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage array.
// Synchronous write, asynchronous read.
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // write port, contents intentionally not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count, thresholds,
// standard/FWFT read and sticky error flags.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_count_w(DEPTH);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AFULL_TH);
  localparam logic [CW-1:0] AE_C   = CW'(AEMPTY_TH);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] rdata;
  logic              full;
  logic              empty;
  logic              wr_ok;
  logic              rd_ok;
  logic              ovf_q;
  logic              unf_q;

  // flags come from the count register only
  assign full  = (count == FULL_C);
  assign empty = (count == '0);

  // acceptance ignores same-cycle opposite op
  assign wr_ok = bus.wr_en & ~full;
  assign rd_ok = bus.rd_en & ~empty;

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok & ~rst),
    .waddr (wr_ptr),
    .wdata (bus.din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // occupancy: both or neither leaves it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case (1'b1)
        (wr_ok & ~rd_ok): count <= count + CW'(1);
        (rd_ok & ~wr_ok): count <= count - CW'(1);
        default:          count <= count;
      endcase
    end
  end

  // sticky errors, a new error beats clr_err
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.wr_en & full)     ovf_q <= 1'b1;
      else if (bus.clr_err)     ovf_q <= 1'b0;
      if (bus.rd_en & empty)    unf_q <= 1'b1;
      else if (bus.clr_err)     unf_q <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // head word shown whenever present
      assign bus.dout       = empty ? '0 : rdata;
      assign bus.dout_valid = ~empty;
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      logic              vld_q;

      // popped word registered, held between reads
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          vld_q <= rd_ok;
          if (rd_ok) dout_q <= rdata;
        end
      end

      assign bus.dout       = dout_q;
      assign bus.dout_valid = vld_q;
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= AF_C);
  assign bus.almost_empty = (count <= AE_C);
  assign bus.count        = count;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo.
// Standard and FWFT instances share stimulus.
module tb_sync_fifo;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] din = 8'h00;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sync_fifo_if #(.DATA_W(8), .DEPTH(16)) f0 ();
  sync_fifo_if #(.DATA_W(8), .DEPTH(16)) f1 ();

  assign f0.wr_en   = wr_en;
  assign f0.din     = din;
  assign f0.rd_en   = rd_en;
  assign f0.clr_err = clr_err;
  assign f1.wr_en   = wr_en;
  assign f1.din     = din;
  assign f1.rd_en   = rd_en;
  assign f1.clr_err = clr_err;

  sync_fifo #(
    .DATA_W(8), .DEPTH(16), .AFULL_TH(14),
    .AEMPTY_TH(2), .FWFT(0)
  ) u_std (.clk(clk), .rst(rst), .bus(f0));

  sync_fifo #(
    .DATA_W(8), .DEPTH(16), .AFULL_TH(14),
    .AEMPTY_TH(2), .FWFT(1)
  ) u_fwft (.clk(clk), .rst(rst), .bus(f1));

  logic [6:0] fl0, fl1;
  logic [2:0] lv0, lv1;
  logic [8:0] rd0, rd1;

  assign fl0 = {f0.full, f0.empty, f0.almost_full,
                f0.almost_empty, f0.overflow,
                f0.underflow, f0.dout_valid};
  assign fl1 = {f1.full, f1.empty, f1.almost_full,
                f1.almost_empty, f1.overflow,
                f1.underflow, f1.dout_valid};
  assign lv0 = {f0.full, f0.almost_full, f0.almost_empty};
  assign lv1 = {f1.full, f1.almost_full, f1.almost_empty};
  assign rd0 = {f0.dout_valid, f0.dout};
  assign rd1 = {f1.dout_valid, f1.dout};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_chk++;
    if (f0.count !== 5'd0)
      $display("FAIL rst_cnt0 got %0d want 0", f0.count);
    else n_pass++;
    n_chk++;
    if (f1.count !== 5'd0)
      $display("FAIL rst_cnt1 got %0d want 0", f1.count);
    else n_pass++;
    n_chk++;
    if (fl0 !== 7'b0101000)
      $display("FAIL rst_fl0 got %b want 0101000", fl0);
    else n_pass++;
    n_chk++;
    if (fl1 !== 7'b0101000)
      $display("FAIL rst_fl1 got %b want 0101000", fl1);
    else n_pass++;
    n_chk++;
    if (f0.dout !== 8'h00)
      $display("FAIL rst_dout0 got %h want 00", f0.dout);
    else n_pass++;
    n_chk++;
    if (f1.dout !== 8'h00)
      $display("FAIL rst_dout1 got %h want 00", f1.dout);
    else n_pass++;
  endtask

  task automatic test_fill_drain();
    logic [2:0] e;
    logic [8:0] ed;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      din   = 8'(i);
      tick();
      e = {(i + 1 == 16), (i + 1 >= 14), (i + 1 <= 2)};
      n_chk++;
      if (f0.count !== 5'(i + 1))
        $display("FAIL fill_cnt0 got %0d want %0d",
                 f0.count, i + 1);
      else n_pass++;
      n_chk++;
      if (lv0 !== e)
        $display("FAIL fill_lvl0 n=%0d got %b want %b",
                 i + 1, lv0, e);
      else n_pass++;
      n_chk++;
      if (lv1 !== e)
        $display("FAIL fill_lvl1 n=%0d got %b want %b",
                 i + 1, lv1, e);
      else n_pass++;
    end
    wr_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      ed = {1'b1, 8'(i)};
      n_chk++;
      if (rd1 !== ed)
        $display("FAIL drain_head1 got %h want %h", rd1, ed);
      else n_pass++;
      tick();
      n_chk++;
      if (rd0 !== ed)
        $display("FAIL drain_dout0 got %h want %h", rd0, ed);
      else n_pass++;
      n_chk++;
      if (f1.count !== 5'(15 - i))
        $display("FAIL drain_cnt1 got %0d want %0d",
                 f1.count, 15 - i);
      else n_pass++;
    end
    rd_en = 1'b0;
    tick();
    n_chk++;
    if (rd0 !== 9'h00F)
      $display("FAIL drain_hold0 got %h want 00f", rd0);
    else n_pass++;
    n_chk++;
    if (fl1 !== 7'b0101000)
      $display("FAIL drain_fl1 got %b want 0101000", fl1);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [8:0] ed;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      din   = 8'(8'h80 + i);
      tick();
    end
    din = 8'hAA;
    tick();
    n_chk++;
    if ({f0.overflow, f1.overflow} !== 2'b11)
      $display("FAIL ovf_set got %b want 11",
               {f0.overflow, f1.overflow});
    else n_pass++;
    n_chk++;
    if (f0.count !== 5'd16)
      $display("FAIL ovf_cnt0 got %0d want 16", f0.count);
    else n_pass++;
    wr_en   = 1'b0;
    clr_err = 1'b1;
    tick();
    n_chk++;
    if ({f0.overflow, f1.overflow} !== 2'b00)
      $display("FAIL ovf_clr got %b want 00",
               {f0.overflow, f1.overflow});
    else n_pass++;
    wr_en = 1'b1;
    tick();
    n_chk++;
    if ({f0.overflow, f1.overflow} !== 2'b11)
      $display("FAIL ovf_setwins got %b want 11",
               {f0.overflow, f1.overflow});
    else n_pass++;
    wr_en = 1'b0;
    tick();
    clr_err = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      ed = {1'b1, 8'(8'h80 + i)};
      n_chk++;
      if (rd1 !== ed)
        $display("FAIL ovf_data1 got %h want %h", rd1, ed);
      else n_pass++;
      tick();
      n_chk++;
      if (rd0 !== ed)
        $display("FAIL ovf_data0 got %h want %h", rd0, ed);
      else n_pass++;
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_underflow();
    rd_en = 1'b1;
    tick();
    n_chk++;
    if ({f0.underflow, f0.dout_valid} !== 2'b10)
      $display("FAIL unf_std got %b want 10",
               {f0.underflow, f0.dout_valid});
    else n_pass++;
    n_chk++;
    if ({f1.underflow, f1.dout_valid} !== 2'b10)
      $display("FAIL unf_fwft got %b want 10",
               {f1.underflow, f1.dout_valid});
    else n_pass++;
    rd_en   = 1'b0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_chk++;
    if ({f0.underflow, f1.underflow} !== 2'b00)
      $display("FAIL unf_clr got %b want 00",
               {f0.underflow, f1.underflow});
    else n_pass++;
    wr_en = 1'b1;
    rd_en = 1'b1;
    din   = 8'h55;
    tick();
    wr_en = 1'b0;
    n_chk++;
    if ({f0.count, f1.count} !== {5'd1, 5'd1})
      $display("FAIL unf_wr_cnt got %0d/%0d want 1/1",
               f0.count, f1.count);
    else n_pass++;
    n_chk++;
    if ({f0.underflow, f1.underflow} !== 2'b11)
      $display("FAIL unf_wr_flag got %b want 11",
               {f0.underflow, f1.underflow});
    else n_pass++;
    n_chk++;
    if (f0.dout_valid !== 1'b0)
      $display("FAIL unf_wr_vld0 got %b want 0",
               f0.dout_valid);
    else n_pass++;
    n_chk++;
    if (rd1 !== 9'h155)
      $display("FAIL unf_wr_head1 got %h want 155", rd1);
    else n_pass++;
    tick();
    rd_en = 1'b0;
    n_chk++;
    if (rd0 !== 9'h155)
      $display("FAIL unf_rd0 got %h want 155", rd0);
    else n_pass++;
    n_chk++;
    if (f0.count !== 5'd0)
      $display("FAIL unf_rd_cnt got %0d want 0", f0.count);
    else n_pass++;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_stream();
    int w = 0;
    int r = 0;
    logic [8:0] ed;
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1;
      din   = 8'(8'h40 + w);
      w++;
      tick();
    end
    for (int k = 0; k < 32; k++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      din   = 8'(8'h40 + w);
      w++;
      ed = {1'b1, 8'(8'h40 + r)};
      r++;
      n_chk++;
      if (rd1 !== ed)
        $display("FAIL strm_head1 got %h want %h", rd1, ed);
      else n_pass++;
      tick();
      n_chk++;
      if (rd0 !== ed)
        $display("FAIL strm_dout0 got %h want %h", rd0, ed);
      else n_pass++;
      n_chk++;
      if ({f0.count, f1.count} !== {5'd8, 5'd8})
        $display("FAIL strm_cnt got %0d/%0d want 8/8",
                 f0.count, f1.count);
      else n_pass++;
    end
    wr_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rd_en = 1'b1;
      ed = {1'b1, 8'(8'h40 + r)};
      r++;
      n_chk++;
      if (rd1 !== ed)
        $display("FAIL strm_tail1 got %h want %h", rd1, ed);
      else n_pass++;
      tick();
      n_chk++;
      if (rd0 !== ed)
        $display("FAIL strm_tail0 got %h want %h", rd0, ed);
      else n_pass++;
      n_chk++;
      if (f0.count !== 5'(7 - k))
        $display("FAIL strm_tcnt got %0d want %0d",
                 f0.count, 7 - k);
      else n_pass++;
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1;
      din   = 8'(8'h10 + i);
      tick();
    end
    n_chk++;
    if (f0.count !== 5'd9)
      $display("FAIL mid_pre got %0d want 9", f0.count);
    else n_pass++;
    rst = 1'b1;
    din = 8'hEE;
    tick();
    rst   = 1'b0;
    wr_en = 1'b0;
    n_chk++;
    if ({f0.count, f1.count} !== 10'd0)
      $display("FAIL mid_cnt got %0d/%0d want 0/0",
               f0.count, f1.count);
    else n_pass++;
    n_chk++;
    if ({f0.empty, f1.empty} !== 2'b11)
      $display("FAIL mid_empty got %b want 11",
               {f0.empty, f1.empty});
    else n_pass++;
    wr_en = 1'b1;
    din   = 8'h3C;
    tick();
    wr_en = 1'b0;
    n_chk++;
    if (rd1 !== 9'h13C)
      $display("FAIL mid_head1 got %h want 13c", rd1);
    else n_pass++;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_chk++;
    if (rd0 !== 9'h13C)
      $display("FAIL mid_dout0 got %h want 13c", rd0);
    else n_pass++;
    n_chk++;
    if ({f0.count, f1.count} !== 10'd0)
      $display("FAIL mid_end got %0d/%0d want 0/0",
               f0.count, f1.count);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_stream();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
